bp_io_cmd_arbiter: RTL and testbench
====================================

Name: bp_io_cmd_arbiter

Overview:
- Shares one BedRock IO command/response channel between two requesters:
  - requester 0: the NBF loader.
  - requester 1: the host/ethernet command source.
- Sits between those requesters and the tethered DUT's IO command port.
- Arbitrates commands round-robin and records the source of each issued command in an in-order tag FIFO.
- Routes every returning response to the requester that issued the matching command, in issue order.

Parameters:
msg_width_p, 128, width of a packed BedRock mem message (cce_mem_msg_width_lp).
max_outstanding_p, 8, max in-flight commands; tag FIFO depth; power of two, >= 2.
count_width_lp, $clog2(max_outstanding_p+1), derived width of the outstanding counter.

Ports:
clk_i  in  1  single clock.
reset_n_i  in  1  asynchronous, active-low reset.
req_cmd_i  in  2*msg_width_p  per-requester command; [msg_width_p-1:0] is requester 0.
req_cmd_v_i  in  2  per-requester command valid.
req_cmd_yumi_o  out  2  per-requester command consumed.
req_resp_o  out  msg_width_p  response data; broadcast to both requesters.
req_resp_v_o  out  2  per-requester response valid.
req_resp_ready_and_i  in  2  per-requester response ready.
io_cmd_o  out  msg_width_p  arbitrated command to the DUT.
io_cmd_v_o  out  1  command valid.
io_cmd_ready_and_i  in  1  DUT ready.
io_resp_i  in  msg_width_p  response from the DUT.
io_resp_v_i  in  1  response valid.
io_resp_yumi_o  out  1  response consumed.
outstanding_o  out  count_width_lp  in-flight command count.
orphan_resp_o  out  1  sticky: a response arrived while no command was outstanding.

Behaviour:
- Reset (reset_n_i=0, asynchronous):
  - tag FIFO emptied; outstanding_o=0; orphan_resp_o=0.
  - last_grant register = 1, so requester 0 wins the first tie.
  - All yumi/valid outputs are combinational and therefore 0 while no inputs are valid.
- Reset mid-operation: in-flight tags are discarded. Responses arriving afterwards count as orphans.
- Arbitration (combinational from req_cmd_v_i, last_grant, full):
  - full = (outstanding_o == max_outstanding_p).
  - If full: no grant; io_cmd_v_o=0.
  - Only one requester valid: grant it.
  - Both valid: grant the requester != last_grant.
  - io_cmd_v_o = |req_cmd_v_i & ~full.
  - io_cmd_o = granted requester's command; 0 when no grant.
  - The grant must not depend on io_cmd_ready_and_i.
- Command issue:
  - Issue fires when io_cmd_v_o & io_cmd_ready_and_i.
  - req_cmd_yumi_o[g] = fire; only the granted bit is ever set.
  - On fire: push g into the tag FIFO and set last_grant <= g.
  - last_grant is unchanged when there is no fire, so a stalled grant stays stable.
  - Zero-cycle latency: a valid command is presented downstream in the same cycle.
- Response routing:
  - head = tag at the FIFO head; empty = (outstanding_o == 0).
  - If !empty: req_resp_v_o[head] = io_resp_v_i; the other bit is 0.
  - io_resp_yumi_o = io_resp_v_i & req_resp_ready_and_i[head].
  - req_resp_o = io_resp_i (pass-through).
  - On yumi: pop the FIFO.
  - A stalled head response blocks all later responses; strict in-order delivery.
- Orphan response:
  - Condition: io_resp_v_i while empty.
  - io_resp_yumi_o=1, which drops the response; req_resp_v_o=0.
  - orphan_resp_o set, sticky until reset.
- Counter arithmetic:
  - outstanding_o next = outstanding_o + push - pop.
  - Push and pop in the same cycle leave it unchanged.
  - full and empty come from the registered count only; there is no bypass.
  - Result: at full, a same-cycle pop does not enable a push. The push waits one cycle.
- FIFO pointers: log2(max_outstanding_p) bits; wrap modulo depth.
- Assertions (nonsynth):
  - Push never occurs when full.
  - At most one req_cmd_yumi_o bit is set per cycle.
  - Pop never occurs when empty, except the orphan drop.

Test Plan:
- Reset:
  - Stimulus: assert reset_n_i=0 with both req_cmd_v_i=2'b11, then release.
  - Required: outstanding_o=0 and orphan_resp_o=0 during reset.
  - Required: the first fire after release grants requester 0.
- Round-robin:
  - Stimulus: both requesters continuously valid, io_cmd_ready_and_i=1, 6 cycles.
  - Required: grant sequence 0,1,0,1,0,1; outstanding_o reaches 6.
- Full back-pressure:
  - Stimulus: requester 1 alone issues 8 commands with no responses.
  - Required: io_cmd_v_o=0 and yumi=0 at outstanding_o=8.
  - Stimulus: one response is yumi'd.
  - Required: the next issue happens exactly one cycle later.
- In-order routing:
  - Stimulus: issue order 0,1,1; return 3 responses A,B,C.
  - Required: A only on req_resp_v_o[0]; B and C only on req_resp_v_o[1].
  - Stimulus: hold req_resp_ready_and_i[1]=0 for 4 cycles on B.
  - Required: io_resp_yumi_o=0 for those 4 cycles; C is not delivered before B.
- Simultaneous push/pop:
  - Stimulus: outstanding_o=3, a command fires and a response pops in the same cycle.
  - Required: outstanding_o stays 3; FIFO head/tail advance correctly across the wrap at index 7->0.
- Orphan:
  - Stimulus: io_resp_v_i=1 with outstanding_o=0.
  - Required: io_resp_yumi_o=1, req_resp_v_o=2'b00, orphan_resp_o=1 and held until reset.

Source files
------------

// File: rtl/bp_io_cmd_arbiter.sv
// Two-requester round-robin arbiter for a shared BedRock IO command channel.
// An in-order tag FIFO routes each response back to the requester that issued it.
module bp_io_cmd_arbiter #(
    parameter  int msg_width_p       = 128,
    parameter  int max_outstanding_p = 8,
    localparam int count_width_lp    = $clog2(max_outstanding_p+1)
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,

    input  logic [2*msg_width_p-1:0]  req_cmd_i,
    input  logic [1:0]                req_cmd_v_i,
    output logic [1:0]                req_cmd_yumi_o,

    output logic [msg_width_p-1:0]    req_resp_o,
    output logic [1:0]                req_resp_v_o,
    input  logic [1:0]                req_resp_ready_and_i,

    output logic [msg_width_p-1:0]    io_cmd_o,
    output logic                      io_cmd_v_o,
    input  logic                      io_cmd_ready_and_i,

    input  logic [msg_width_p-1:0]    io_resp_i,
    input  logic                      io_resp_v_i,
    output logic                      io_resp_yumi_o,

    output logic [count_width_lp-1:0] outstanding_o,
    output logic                      orphan_resp_o
);

    localparam int ptr_width_lp = $clog2(max_outstanding_p);
    localparam logic [count_width_lp-1:0] full_cnt_lp =
        count_width_lp'(max_outstanding_p);

    logic                      tags_q [max_outstanding_p];
    logic [ptr_width_lp-1:0]   wptr_q, wptr_d;
    logic [ptr_width_lp-1:0]   rptr_q, rptr_d;
    logic [count_width_lp-1:0] cnt_q, cnt_d;
    logic                      last_q, last_d;
    logic                      orphan_q, orphan_d;

    logic full, empty;
    logic gnt_v, gnt;
    logic fire, push, pop;
    logic head;

    assign full  = (cnt_q == full_cnt_lp);
    assign empty = (cnt_q == '0);
    assign head  = tags_q[rptr_q];

    // Grant is a function of valids, history and occupancy only, never of ready.
    always_comb begin
        gnt_v = 1'b0;
        gnt   = 1'b0;
        if (!full) begin
            case (req_cmd_v_i)
                2'b01: begin
                    gnt_v = 1'b1;
                    gnt   = 1'b0;
                end
                2'b10: begin
                    gnt_v = 1'b1;
                    gnt   = 1'b1;
                end
                2'b11: begin
                    gnt_v = 1'b1;
                    gnt   = ~last_q;
                end
                default: begin
                    gnt_v = 1'b0;
                    gnt   = 1'b0;
                end
            endcase
        end
    end

    assign io_cmd_v_o = gnt_v;
    assign fire       = gnt_v & io_cmd_ready_and_i;
    assign push       = fire;

    always_comb begin
        io_cmd_o = '0;
        if (gnt_v) begin
            io_cmd_o = gnt ? req_cmd_i[2*msg_width_p-1:msg_width_p]
                           : req_cmd_i[msg_width_p-1:0];
        end
    end

    always_comb begin
        req_cmd_yumi_o = 2'b00;
        if (fire) begin
            req_cmd_yumi_o = gnt ? 2'b10 : 2'b01;
        end
    end

    // With nothing outstanding a response is an orphan: consume and drop it.
    always_comb begin
        req_resp_v_o   = 2'b00;
        io_resp_yumi_o = io_resp_v_i;
        if (!empty) begin
            req_resp_v_o   = head ? {io_resp_v_i, 1'b0} : {1'b0, io_resp_v_i};
            io_resp_yumi_o = io_resp_v_i & req_resp_ready_and_i[head];
        end
    end

    assign req_resp_o = io_resp_i;
    assign pop        = io_resp_yumi_o & ~empty;

    always_comb begin
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        cnt_d    = cnt_q;
        last_d   = last_q;
        orphan_d = orphan_q;
        if (push) begin
            wptr_d = wptr_q + 1'b1;
            last_d = gnt;
        end
        if (pop) begin
            rptr_d = rptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
        if (io_resp_v_i && empty) begin
            orphan_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            cnt_q    <= '0;
            last_q   <= 1'b1;
            orphan_q <= 1'b0;
            for (int i = 0; i < max_outstanding_p; i++) begin
                tags_q[i] <= 1'b0;
            end
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            cnt_q    <= cnt_d;
            last_q   <= last_d;
            orphan_q <= orphan_d;
            if (push) begin
                tags_q[wptr_q] <= gnt;
            end
        end
    end

    assign outstanding_o = cnt_q;
    assign orphan_resp_o = orphan_q;

`ifndef SYNTHESIS
    a_no_push_full: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        !(push && full));
    a_yumi_onehot: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        $onehot0(req_cmd_yumi_o));
    a_no_pop_empty: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        !(io_resp_yumi_o && empty && !io_resp_v_i));
`endif

endmodule

// File: tb/tb_bp_io_cmd_arbiter.sv
// Directed bench for bp_io_cmd_arbiter with a tag scoreboard of expected
// response routing and a small reference model of grant/count/orphan state.
module tb_bp_io_cmd_arbiter;

    localparam int W = 128;
    localparam int D = 8;
    localparam int CW = $clog2(D+1);

    logic           clk = 1'b0;
    logic           reset_n_i = 1'b0;
    logic [2*W-1:0] req_cmd_i = '0;
    logic [1:0]     req_cmd_v_i = '0;
    logic [1:0]     req_cmd_yumi_o;
    logic [W-1:0]   req_resp_o;
    logic [1:0]     req_resp_v_o;
    logic [1:0]     req_resp_ready_and_i = '0;
    logic [W-1:0]   io_cmd_o;
    logic           io_cmd_v_o;
    logic           io_cmd_ready_and_i = 1'b0;
    logic [W-1:0]   io_resp_i = '0;
    logic           io_resp_v_i = 1'b0;
    logic           io_resp_yumi_o;
    logic [CW-1:0]  outstanding_o;
    logic           orphan_resp_o;

    always #5 clk = ~clk;

    bp_io_cmd_arbiter #(
        .msg_width_p      (W),
        .max_outstanding_p(D)
    ) dut (
        .clk_i               (clk),
        .reset_n_i           (reset_n_i),
        .req_cmd_i           (req_cmd_i),
        .req_cmd_v_i         (req_cmd_v_i),
        .req_cmd_yumi_o      (req_cmd_yumi_o),
        .req_resp_o          (req_resp_o),
        .req_resp_v_o        (req_resp_v_o),
        .req_resp_ready_and_i(req_resp_ready_and_i),
        .io_cmd_o            (io_cmd_o),
        .io_cmd_v_o          (io_cmd_v_o),
        .io_cmd_ready_and_i  (io_cmd_ready_and_i),
        .io_resp_i           (io_resp_i),
        .io_resp_v_i         (io_resp_v_i),
        .io_resp_yumi_o      (io_resp_yumi_o),
        .outstanding_o       (outstanding_o),
        .orphan_resp_o       (orphan_resp_o)
    );

    int total = 0;
    int bad = 0;
    bit sb[$];
    bit mlast = 1'b1;
    int mcnt = 0;
    bit morph = 1'b0;

    function automatic logic [W-1:0] rnd();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs,
                       input logic [W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle at the negedge, check combinational outputs against the
    // model, then advance the model for the coming posedge.
    task automatic step(input logic [1:0] v, input logic rdy,
                        input logic rv, input logic [1:0] rr);
        logic [W-1:0] c0, c1;
        logic [1:0]   ey;
        bit           g, h, push, pop, orph;
        @(negedge clk);
        c0 = rnd();
        c1 = rnd();
        req_cmd_i            = {c1, c0};
        req_cmd_v_i          = v;
        io_cmd_ready_and_i   = rdy;
        io_resp_v_i          = rv;
        io_resp_i            = rnd();
        req_resp_ready_and_i = rr;
        #1;
        chk("outstanding", outstanding_o, mcnt);
        chk("orphan", orphan_resp_o, morph);
        push = 1'b0;
        pop  = 1'b0;
        orph = 1'b0;
        if (mcnt != D && v != 2'b00) begin
            g  = (v == 2'b11) ? ~mlast : v[1];
            ey = rdy ? (g ? 2'b10 : 2'b01) : 2'b00;
            chk("cmd_v", io_cmd_v_o, 1'b1);
            chk("cmd_data", io_cmd_o, g ? c1 : c0);
            chk("cmd_yumi", req_cmd_yumi_o, ey);
            push = rdy;
        end else begin
            chk("cmd_v_idle", io_cmd_v_o, 1'b0);
            chk("cmd_data_idle", io_cmd_o, '0);
            chk("cmd_yumi_idle", req_cmd_yumi_o, 2'b00);
        end
        chk("resp_data", req_resp_o, io_resp_i);
        if (!rv) begin
            chk("resp_v_idle", req_resp_v_o, 2'b00);
            chk("resp_yumi_idle", io_resp_yumi_o, 1'b0);
        end else if (sb.size() == 0) begin
            chk("orphan_yumi", io_resp_yumi_o, 1'b1);
            chk("orphan_resp_v", req_resp_v_o, 2'b00);
            orph = 1'b1;
        end else begin
            h = sb[0];
            chk("route_resp_v", req_resp_v_o, h ? 2'b10 : 2'b01);
            chk("route_yumi", io_resp_yumi_o, rr[h]);
            pop = rr[h];
        end
        if (pop) void'(sb.pop_front());
        if (push) begin
            sb.push_back(g);
            mlast = g;
        end
        mcnt = mcnt + int'(push) - int'(pop);
        if (orph) morph = 1'b1;
    endtask

    task automatic rst();
        @(negedge clk);
        reset_n_i            = 1'b0;
        req_cmd_v_i          = 2'b11;
        io_cmd_ready_and_i   = 1'b0;
        io_resp_v_i          = 1'b0;
        req_resp_ready_and_i = 2'b00;
        #1;
        chk("rst_outstanding", outstanding_o, 0);
        chk("rst_orphan", orphan_resp_o, 1'b0);
        @(negedge clk);
        chk("rst_outstanding_hold", outstanding_o, 0);
        chk("rst_orphan_hold", orphan_resp_o, 1'b0);
        reset_n_i = 1'b1;
        sb.delete();
        mlast = 1'b1;
        mcnt  = 0;
        morph = 1'b0;
    endtask

    initial begin
        bit exp_rr[6];
        exp_rr = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

        rst();

        for (int i = 0; i < 6; i++) begin
            step(2'b11, 1'b1, 1'b0, 2'b00);
            chk("rr_grant", req_cmd_yumi_o, exp_rr[i] ? 2'b10 : 2'b01);
        end
        step(2'b00, 1'b0, 1'b0, 2'b00);
        chk("rr_outstanding", outstanding_o, 6);
        repeat (6) step(2'b00, 1'b0, 1'b1, 2'b11);
        step(2'b00, 1'b0, 1'b0, 2'b00);
        chk("rr_drained", outstanding_o, 0);

        repeat (8) step(2'b10, 1'b1, 1'b0, 2'b00);
        repeat (2) begin
            step(2'b10, 1'b1, 1'b0, 2'b00);
            chk("full_count", outstanding_o, 8);
            chk("full_cmd_v", io_cmd_v_o, 1'b0);
            chk("full_yumi", req_cmd_yumi_o, 2'b00);
        end
        step(2'b10, 1'b1, 1'b1, 2'b11);
        chk("full_pop_yumi", io_resp_yumi_o, 1'b1);
        chk("full_pop_no_push", io_cmd_v_o, 1'b0);
        step(2'b10, 1'b1, 1'b0, 2'b00);
        chk("issue_after_pop_cnt", outstanding_o, 7);
        chk("issue_after_pop", req_cmd_yumi_o, 2'b10);
        repeat (8) step(2'b00, 1'b0, 1'b1, 2'b11);
        step(2'b00, 1'b0, 1'b0, 2'b00);
        chk("full_drained", outstanding_o, 0);

        step(2'b01, 1'b1, 1'b0, 2'b00);
        step(2'b10, 1'b1, 1'b0, 2'b00);
        step(2'b10, 1'b1, 1'b0, 2'b00);
        step(2'b00, 1'b0, 1'b1, 2'b11);
        chk("order_A", req_resp_v_o, 2'b01);
        repeat (4) begin
            step(2'b00, 1'b0, 1'b1, 2'b01);
            chk("order_B_stall_v", req_resp_v_o, 2'b10);
            chk("order_B_stall_yumi", io_resp_yumi_o, 1'b0);
            chk("order_B_stall_cnt", outstanding_o, 2);
        end
        step(2'b00, 1'b0, 1'b1, 2'b11);
        chk("order_B", req_resp_v_o, 2'b10);
        step(2'b00, 1'b0, 1'b1, 2'b11);
        chk("order_C", req_resp_v_o, 2'b10);
        step(2'b00, 1'b0, 1'b0, 2'b00);
        chk("order_drained", outstanding_o, 0);

        repeat (3) step(2'b01, 1'b1, 1'b0, 2'b00);
        repeat (9) begin
            step(2'b11, 1'b1, 1'b1, 2'b11);
            chk("pushpop_cnt", outstanding_o, 3);
            chk("pushpop_yumi", io_resp_yumi_o, 1'b1);
        end
        step(2'b00, 1'b0, 1'b0, 2'b00);
        chk("pushpop_hold", outstanding_o, 3);
        repeat (3) step(2'b00, 1'b0, 1'b1, 2'b11);

        step(2'b00, 1'b0, 1'b1, 2'b00);
        chk("orphan_drop_yumi", io_resp_yumi_o, 1'b1);
        chk("orphan_drop_v", req_resp_v_o, 2'b00);
        step(2'b00, 1'b0, 1'b0, 2'b00);
        chk("orphan_set", orphan_resp_o, 1'b1);
        step(2'b01, 1'b1, 1'b0, 2'b00);
        step(2'b00, 1'b0, 1'b1, 2'b11);
        step(2'b00, 1'b0, 1'b0, 2'b00);
        chk("orphan_sticky", orphan_resp_o, 1'b1);
        rst();

        step(2'b11, 1'b1, 1'b0, 2'b00);
        step(2'b11, 1'b1, 1'b0, 2'b00);
        rst();
        step(2'b00, 1'b0, 1'b1, 2'b11);
        chk("midrst_orphan_v", req_resp_v_o, 2'b00);
        step(2'b00, 1'b0, 1'b0, 2'b00);
        chk("midrst_orphan", orphan_resp_o, 1'b1);
        rst();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
